query_crc5_tx: RTL and testbench
================================

Name: query_crc5_tx

Overview:
- Reader-side serializer for EPC Gen2 commands that carry a CRC-5, such as Query.
- Loads a parallel command payload and shifts it out MSB first, one bit per accepted handshake.
- Computes CRC-5 on the fly (x^5+x^3+1, preset 01001) and appends the 5 CRC bits MSB first.
- Feeds the reader's PIE modulator; the tag-side CRC-5 checker sees residue 00000 on a good frame.

Parameters:
- PAYLOAD_W, 17, payload bits before CRC (Query = 4 cmd + 13 field bits).
- CRC_PRESET, 5'b01001, CRC register value at frame start.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  pulse; loads payload and begins a frame (accepted only in IDLE)
- payload  in  PAYLOAD_W  command bits; bit [PAYLOAD_W-1] is sent first
- abort  in  1  synchronous frame abort
- bit_out  out  1  current serial bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  downstream accepts bit_out this cycle
- bit_last  out  1  high with the final CRC bit
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last bit is accepted
- crc_out  out  5  CRC register; holds the final CRC after the frame

Behaviour:
- Reset when reset_n=0 at a clk edge: state=IDLE, bit_out=0, bit_valid=0, bit_last=0, busy=0, done=0, crc_out=CRC_PRESET, bit counter=0.
- Reset takes priority over everything. Mid-frame reset abandons the frame and does not pulse done.
- States: IDLE, PAYLOAD, CRC, DONE.
- IDLE:
  - start=1 → latch payload into the shift register, crc=CRC_PRESET, count=0, go to PAYLOAD.
  - bit_valid and busy rise in the next cycle (latency 1).
- PAYLOAD:
  - bit_valid=1, bit_out=shreg MSB.
  - On bit_valid&&bit_ready:
    - shift the register left;
    - fb = bit_out ^ crc[4];
    - crc <= {crc[3], crc[2]^fb, crc[1], crc[0], fb};
    - count++.
  - After bit PAYLOAD_W-1 is accepted → CRC, count=0.
- CRC:
  - bit_out=crc[4], bit_valid=1.
  - On accept: crc <= {crc[3:0],1'b0}, count++. The emitted CRC is frozen for crc_out via a separate 5-bit hold register loaded on entry to CRC.
  - bit_last=1 when count==4. Accepting that bit → DONE.
- DONE: done=1, bit_valid=0, busy=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- Stall: while bit_ready=0, bit_out, bit_last and all state hold unchanged.
- start while busy: ignored; payload is not resampled.
- abort (PAYLOAD or CRC): next cycle state=IDLE, bit_valid=0, busy=0, no done. crc_out keeps its last value.
  - abort and an accept in the same cycle: abort wins, the accept is discarded.
  - abort in IDLE or DONE: no effect.
- Frame length: always PAYLOAD_W+5 accepted bits. Bit counter is 5 bits wide and never wraps within a frame.

Optional Feature:
- Macro: QUERY_CRC5_ERR_INJECT_EN.
- Defined:
  - adds input err_inject (1 bit), sampled with start;
  - if it was set, the final CRC bit is sent inverted (bit_out = ~crc[4] while bit_last=1);
  - crc_out reports the true, uninverted CRC;
  - used to verify tag CRC rejection.
- Undefined: no port, no inversion logic.

Decomposition:
- Shared package crc5_pkg:
  - CRC5_PRESET = 5'b01001;
  - CRC5_RESIDUE = 5'b00000;
  - QUERY_CMD = 4'b1000;
  - QUERY_PAYLOAD_W = 17;
  - state enum typedef (IDLE/PAYLOAD/CRC/DONE);
  - function crc5_step(crc, bit) returning the next CRC.
- The CRC update is the natural sub-module crc5_gen: sync active-low reset, init and shift enables, serial in, 5-bit register. The same function is reused by the bench's reference model.

Test Plan:
- Query, all fields zero: payload=17'h10000, bit_ready=1.
  - Expect 22-bit stream 0x200010 (CRC bits 1,0,0,0,0), crc_out=5'b10000.
  - bit_valid 22 cycles starting the cycle after start; done the cycle after bit_last.
- Same payload, bit_ready random 50%: identical stream. bit_out and bit_last are stable during every stall cycle. done arrives exactly once.
- Start while busy: second start at bit 5 with payload 17'h1FFFF is ignored; the stream is still 0x200010.
- Abort at bit 9: bit_valid=0 the next cycle, no done. A following start with 17'h10000 yields 0x200010 again, proving the CRC re-preset.
- reset_n=0 during CRC bit 2: all outputs return to reset values next cycle. A frame after reset is correct.
- 1000 random payloads streamed into a CRC-5 checker model: residue 5'b00000 every frame.
  - With QUERY_CRC5_ERR_INJECT_EN and err_inject=1: stream 0x200011, residue nonzero.

Source files
------------

// File: rtl/crc5_pkg.sv
// ---------------------------------------------------------------------------
// crc5_pkg
// Shared definitions for the EPC Gen2 CRC-5 command path (x^5 + x^3 + 1).
// Contents:
//   CRC5_PRESET      register value at frame start
//   CRC5_RESIDUE     checker residue over a good frame (payload + CRC)
//   QUERY_CMD        4-bit Query command code
//   QUERY_PAYLOAD_W  Query payload width before CRC
//   tx_state_t       serializer states
//   crc5_step()      one serial CRC-5 update, MSB-first
// ---------------------------------------------------------------------------
package crc5_pkg;

  localparam logic [4:0] CRC5_PRESET     = 5'b01001;
  localparam logic [4:0] CRC5_RESIDUE    = 5'b00000;
  localparam logic [3:0] QUERY_CMD       = 4'b1000;
  localparam int         QUERY_PAYLOAD_W = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2,
    DONE    = 2'd3
  } tx_state_t;

  // Feedback is the incoming bit XOR the register MSB; it re-enters at bit 0
  // and is folded into bit 3 (the x^3 tap).
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[4];
    return {crc[3], crc[2] ^ fb, crc[1], crc[0], fb};
  endfunction

endpackage

// File: rtl/crc5_gen.sv
// ---------------------------------------------------------------------------
// crc5_gen
// Serial CRC-5 register. Presets on init, advances one bit on shift.
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset (register -> PRESET)
//   init       load PRESET (wins over shift)
//   shift      advance by one serial bit
//   serial_in  bit fed into the CRC
//   crc        current register value
// ---------------------------------------------------------------------------
module crc5_gen
  import crc5_pkg::*;
#(
  parameter logic [4:0] PRESET = CRC5_PRESET
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init,
  input  logic       shift,
  input  logic       serial_in,
  output logic [4:0] crc
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc <= PRESET;
    end else if (init) begin
      crc <= PRESET;
    end else if (shift) begin
      crc <= crc5_step(crc, serial_in);
    end
  end

endmodule

// File: rtl/query_crc5_tx.sv
// ---------------------------------------------------------------------------
// query_crc5_tx
// Reader-side serializer for CRC-5 protected EPC Gen2 commands (e.g. Query).
// Shifts the payload out MSB first on a valid/ready handshake, then appends
// the 5 CRC bits MSB first.
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   start      pulse; loads payload and begins a frame (IDLE only)
//   payload    command bits, payload[PAYLOAD_W-1] sent first
//   abort      synchronous frame abort (PAYLOAD/CRC only)
//   bit_out    current serial bit
//   bit_valid  bit_out is valid
//   bit_ready  downstream accepts bit_out this cycle
//   bit_last   high with the final CRC bit
//   busy       frame in progress
//   done       one-cycle pulse after the last bit is accepted
//   crc_out    running CRC during payload, frozen final CRC afterwards
// Optional build macro QUERY_CRC5_ERR_INJECT_EN adds input err_inject,
// sampled with start; when set, the final CRC bit goes out inverted while
// crc_out still reports the true CRC.
// ---------------------------------------------------------------------------
module query_crc5_tx
  import crc5_pkg::*;
#(
  parameter int         PAYLOAD_W  = QUERY_PAYLOAD_W,
  parameter logic [4:0] CRC_PRESET = CRC5_PRESET
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 abort,
`ifdef QUERY_CRC5_ERR_INJECT_EN
  input  logic                 err_inject,
`endif
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 bit_last,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           crc_out
);

  localparam logic [4:0] LAST_PAYLOAD = 5'(PAYLOAD_W - 1);
  localparam logic [4:0] LAST_CRC     = 5'd4;

  tx_state_t            state, state_next;
  logic [PAYLOAD_W-1:0] shreg;
  logic [4:0]           count;
  logic [4:0]           crc;
  logic [4:0]           crc_hold;
  logic                 load;
  logic                 accept;
  logic                 crc_serial;
`ifdef QUERY_CRC5_ERR_INJECT_EN
  logic                 inject_q;
`endif

  // An abort in the same cycle as a handshake discards the handshake.
  assign load    = (state == IDLE) && start;
  assign accept  = bit_valid && bit_ready && !abort;
  assign crc_out = crc_hold;

  // During CRC the register is fed its own MSB, which makes the feedback zero
  // and turns the update into a plain left shift with zero fill.
  assign crc_serial = (state == CRC) ? crc[4] : shreg[PAYLOAD_W-1];

  crc5_gen #(
    .PRESET(CRC_PRESET)
  ) u_crc5_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .init     (load),
    .shift    (accept),
    .serial_in(crc_serial),
    .crc      (crc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bit_out    = 1'b0;
    bit_valid  = 1'b0;
    bit_last   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        bit_valid = 1'b1;
        busy      = 1'b1;
        bit_out   = shreg[PAYLOAD_W-1];
        if (abort) begin
          state_next = IDLE;
        end else if (accept && (count == LAST_PAYLOAD)) begin
          state_next = CRC;
        end
      end
      CRC: begin
        bit_valid = 1'b1;
        busy      = 1'b1;
        bit_last  = (count == LAST_CRC);
`ifdef QUERY_CRC5_ERR_INJECT_EN
        bit_out   = crc[4] ^ (inject_q && bit_last);
`else
        bit_out   = crc[4];
`endif
        if (abort) begin
          state_next = IDLE;
        end else if (accept && bit_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // crc_hold follows the CRC register's next value on every payload bit, so
  // it stops at the final CRC as the frame enters CRC and then stays put while
  // the live register shifts the CRC out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg    <= '0;
      count    <= '0;
      crc_hold <= CRC_PRESET;
    end else if (load) begin
      shreg    <= payload;
      count    <= '0;
      crc_hold <= CRC_PRESET;
    end else if (accept) begin
      if (state == PAYLOAD) begin
        shreg    <= {shreg[PAYLOAD_W-2:0], 1'b0};
        crc_hold <= crc5_step(crc, shreg[PAYLOAD_W-1]);
        count    <= (count == LAST_PAYLOAD) ? 5'd0 : count + 5'd1;
      end else begin
        count <= count + 5'd1;
      end
    end
  end

`ifdef QUERY_CRC5_ERR_INJECT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inject_q <= 1'b0;
    end else if (load) begin
      inject_q <= err_inject;
    end
  end
`endif

endmodule

// File: tb/tb_query_crc5_tx.sv
// ---------------------------------------------------------------------------
// tb_query_crc5_tx
// Directed bench for query_crc5_tx: all-zero Query frame, random back-pressure,
// start while busy, abort, mid-CRC reset and a batch of random payloads run
// through a CRC-5 checker. Honours QUERY_CRC5_ERR_INJECT_EN.
// ---------------------------------------------------------------------------
module tb_query_crc5_tx;
  import crc5_pkg::*;

  localparam int PW = QUERY_PAYLOAD_W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          bit_ready = 1'b0;
  logic [PW-1:0] payload = '0;
`ifdef QUERY_CRC5_ERR_INJECT_EN
  logic          err_inject = 1'b0;
`endif
  logic          bit_out, bit_valid, bit_last, busy, done;
  logic [4:0]    crc_out;

  int compared   = 0;
  int mismatched = 0;

  // Results of the most recent applyStimulus call
  logic [31:0] rx_stream;
  int          rx_bits, rx_done;
  logic        stall_ok, first_valid, done_timing_ok, ended;
  logic [4:0]  rx_residue;
  logic        snap_valid, snap_busy, snap_done, snap_last, snap_bit;
  logic [4:0]  snap_crc;

  always #5 clk = ~clk;

  query_crc5_tx #(
    .PAYLOAD_W (PW),
    .CRC_PRESET(CRC5_PRESET)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .payload   (payload),
    .abort     (abort),
`ifdef QUERY_CRC5_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_last  (bit_last),
    .busy      (busy),
    .done      (done),
    .crc_out   (crc_out)
  );

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one frame from IDLE. All inputs change at negedge; the bit recorded
  // in an iteration is the one the DUT accepts at the following posedge.
  // restart_at/abort_at/reset_at fire when that many bits have been accepted
  // (-1 disables). The loop stops 3 cycles after done, abort or reset.
  task automatic applyStimulus(input logic [PW-1:0] p, input logic inj, input logic rand_ready,
                               input int restart_at, input int abort_at, input int reset_at);
    int   tail, last_acc_cyc;
    logic fired, prev_stall, prev_bit, prev_last;
    rx_stream      = '0;
    rx_bits        = 0;
    rx_done        = 0;
    stall_ok       = 1'b1;
    done_timing_ok = 1'b1;
    rx_residue     = CRC5_PRESET;
    ended          = 1'b0;
    fired          = 1'b0;
    prev_stall     = 1'b0;
    prev_bit       = 1'b0;
    prev_last      = 1'b0;
    tail           = 0;
    last_acc_cyc   = -10;
    @(negedge clk);
    payload = p;
    start   = 1'b1;
`ifdef QUERY_CRC5_ERR_INJECT_EN
    err_inject = inj;
`else
    if (inj) $display("[TB] err_inject requested but feature not built");
`endif
    @(negedge clk);
    start       = 1'b0;
    first_valid = bit_valid && busy;
    for (int cyc = 0; cyc < 400 && !(ended && tail >= 3); cyc++) begin
      if (ended) tail++;
      if (done) begin
        rx_done++;
        if (cyc != last_acc_cyc + 1) done_timing_ok = 1'b0;
        ended = 1'b1;
      end
      if (prev_stall && (bit_out !== prev_bit || bit_last !== prev_last)) stall_ok = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      reset_n   = 1'b1;
      bit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!fired && bit_valid && rx_bits == restart_at) begin
        start   = 1'b1;
        payload = '1;
        fired   = 1'b1;
      end
      if (!fired && bit_valid && rx_bits == abort_at) begin
        abort     = 1'b1;
        bit_ready = 1'b1;
        fired     = 1'b1;
      end
      if (!fired && bit_valid && rx_bits == reset_at) begin
        reset_n = 1'b0;
        fired   = 1'b1;
      end
      if (bit_valid && bit_ready && !abort && reset_n) begin
        rx_stream  = {rx_stream[30:0], bit_out};
        rx_bits++;
        rx_residue = crc5_step(rx_residue, bit_out);
        if (bit_last) last_acc_cyc = cyc;
      end
      prev_stall = bit_valid && !bit_ready && !abort && reset_n;
      prev_bit   = bit_out;
      prev_last  = bit_last;
      @(negedge clk);
      if (abort || !reset_n) begin
        snap_valid = bit_valid;
        snap_busy  = busy;
        snap_done  = done;
        snap_last  = bit_last;
        snap_bit   = bit_out;
        snap_crc   = crc_out;
        ended      = 1'b1;
      end
    end
    start   = 1'b0;
    abort   = 1'b0;
    reset_n = 1'b1;
`ifdef QUERY_CRC5_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    checkOutput("frame_ended", 32'(ended), 32'd1);
  endtask

  initial begin
    logic [PW-1:0] rp;
    logic [4:0]    model_crc;

    $display("[TB] query_crc5_tx bench starting");

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_bit_valid", 32'(bit_valid), 32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_done",      32'(done),      32'd0);
    checkOutput("rst_bit_last",  32'(bit_last),  32'd0);
    checkOutput("rst_bit_out",   32'(bit_out),   32'd0);
    checkOutput("rst_crc_out",   32'(crc_out),   32'h09);
    reset_n = 1'b1;
    @(negedge clk);

    // All-zero Query: 1 + 16 zeros, CRC 10000
    applyStimulus(17'h10000, 1'b0, 1'b0, -1, -1, -1);
    checkOutput("q0_stream",      rx_stream,               32'h0020_0010);
    checkOutput("q0_bits",        32'(rx_bits),            32'd22);
    checkOutput("q0_first_valid", 32'(first_valid),        32'd1);
    checkOutput("q0_done_count",  32'(rx_done),            32'd1);
    checkOutput("q0_done_timing", 32'(done_timing_ok),     32'd1);
    checkOutput("q0_crc_out",     32'(crc_out),            32'h10);
    checkOutput("q0_residue",     32'(rx_residue),         32'h00);
    checkOutput("q0_idle_busy",   32'(busy),               32'd0);

    // Random back-pressure
    applyStimulus(17'h10000, 1'b0, 1'b1, -1, -1, -1);
    checkOutput("bp_stream",      rx_stream,           32'h0020_0010);
    checkOutput("bp_stall_hold",  32'(stall_ok),       32'd1);
    checkOutput("bp_done_count",  32'(rx_done),        32'd1);
    checkOutput("bp_done_timing", 32'(done_timing_ok), 32'd1);

    // Start while busy at bit 5 with all-ones payload
    applyStimulus(17'h10000, 1'b0, 1'b0, 5, -1, -1);
    checkOutput("rs_stream",     rx_stream,    32'h0020_0010);
    checkOutput("rs_done_count", 32'(rx_done), 32'd1);

    // Abort at bit 9; CRC after 9 accepted bits is 10110
    applyStimulus(17'h10000, 1'b0, 1'b0, -1, 9, -1);
    checkOutput("ab_bits",      32'(rx_bits),    32'd9);
    checkOutput("ab_valid",     32'(snap_valid), 32'd0);
    checkOutput("ab_busy",      32'(snap_busy),  32'd0);
    checkOutput("ab_done",      32'(rx_done),    32'd0);
    checkOutput("ab_crc_kept",  32'(snap_crc),   32'h16);
    applyStimulus(17'h10000, 1'b0, 1'b0, -1, -1, -1);
    checkOutput("ab_next_stream", rx_stream,  32'h0020_0010);
    checkOutput("ab_next_done",   32'(rx_done), 32'd1);

    // Reset during CRC bit 2
    applyStimulus(17'h10000, 1'b0, 1'b0, -1, -1, PW + 2);
    checkOutput("mr_valid", 32'(snap_valid), 32'd0);
    checkOutput("mr_busy",  32'(snap_busy),  32'd0);
    checkOutput("mr_done",  32'(snap_done),  32'd0);
    checkOutput("mr_last",  32'(snap_last),  32'd0);
    checkOutput("mr_bit",   32'(snap_bit),   32'd0);
    checkOutput("mr_crc",   32'(snap_crc),   32'h09);
    checkOutput("mr_no_done", 32'(rx_done),  32'd0);
    applyStimulus(17'h10000, 1'b0, 1'b0, -1, -1, -1);
    checkOutput("mr_next_stream", rx_stream,     32'h0020_0010);
    checkOutput("mr_next_crc",    32'(crc_out),  32'h10);

`ifdef QUERY_CRC5_ERR_INJECT_EN
    // Inverted final CRC bit, true CRC still reported
    applyStimulus(17'h10000, 1'b1, 1'b0, -1, -1, -1);
    checkOutput("inj_stream",   rx_stream,                  32'h0020_0011);
    checkOutput("inj_residue",  32'(rx_residue != 5'd0),    32'd1);
    checkOutput("inj_crc_out",  32'(crc_out),               32'h10);
    applyStimulus(17'h10000, 1'b0, 1'b0, -1, -1, -1);
    checkOutput("inj_off_stream", rx_stream, 32'h0020_0010);
`endif

    // Random payloads through a CRC-5 checker
    for (int n = 0; n < 1000; n++) begin
      rp = PW'($urandom);
      model_crc = CRC5_PRESET;
      for (int i = PW - 1; i >= 0; i--) model_crc = crc5_step(model_crc, rp[i]);
      applyStimulus(rp, 1'b0, 1'b0, -1, -1, -1);
      checkOutput("rnd_residue", 32'(rx_residue),     32'(CRC5_RESIDUE));
      checkOutput("rnd_payload", 32'(rx_stream[26:5]), 32'(rp));
      checkOutput("rnd_crc_out", 32'(crc_out),        32'(model_crc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
